// File: rtl/pipe_pkg.sv
// Shared pipeline types and defaults.
// Used by the fetch stage and the ID/EX register.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HELD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel.
// A request is held until a one-cycle ready pulse.
interface fetch_stage_if #(
  parameter int W = 32
) ();

  logic         req;
  logic [W-1:0] addr;
  logic         ready;
  logic [W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );

endinterface

// File: rtl/fetch_stage.sv
// PC register, fetch FSM and IF/ID pipeline register.
// Handles stalls, redirects and variable-latency imem.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  =
    ADDR_W'(PIPE_RESET_PC),
  parameter logic [ADDR_W-1:0] NOP_INSTR =
    ADDR_W'(PIPE_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              pc_wen,
  input  logic              delay,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_stage_if.master     imem,
  output logic [ADDR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] pc_out
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] old_q, old_d;

  logic              stall;
  logic              kill;
  logic [ADDR_W-1:0] kill_pc;
  logic [ADDR_W-1:0] pc_inc;

  assign stall   = delay | ~pc_wen;
  assign kill    = flush | redirect;
  assign pc_inc  = pc_q + ADDR_W'(4);
  assign kill_pc = redirect
                 ? (redirect_pc & ~ADDR_W'(3))
                 : pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    old_d   = old_q;
    unique case (state_q)
      FETCH: begin
        if (kill) begin
          pc_d    = kill_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          // response still owed: wait it out at the old address
          if (!imem.ready) begin
            old_d   = pc_q;
            state_d = DISCARD;
          end
        end else if (imem.ready) begin
          if (stall) begin
            buf_d   = imem.rdata;
            state_d = HELD;
          end else begin
            instr_d = imem.rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end
      end
      HELD: begin
        if (kill) begin
          pc_d    = kill_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          buf_d   = '0;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = buf_q;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (kill) begin
          pc_d    = kill_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
        if (imem.ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      buf_q   <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
      old_q   <= old_d;
    end
  end

  assign imem.req  = ~reset & (state_q != HELD);
  assign imem.addr = (state_q == DISCARD) ? old_q : pc_q;

  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign pc_out     = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage
// against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        pc_wen;
  logic        delay;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] pc_out;

  fetch_stage_if #(.W(32)) imem ();

  fetch_stage #(.ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .pc_wen      (pc_wen),
    .delay       (delay),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: a held response lives in m_q;
  // m_stale marks an abandoned request still owed a reply
  logic [31:0] m_pc, m_instr, m_pc4, m_old;
  bit          m_valid, m_stale;
  logic [31:0] m_q[$];

  function automatic bit m_req();
    return !reset && m_q.size() == 0;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_stale ? m_old : m_pc;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic m_kill();
    if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
    m_instr = NOP;
    m_valid = 0;
  endtask

  task automatic m_update();
    bit stl, kil;
    stl = delay || !pc_wen;
    kil = flush || redirect;
    if (reset) begin
      m_pc = 32'h0; m_instr = NOP; m_pc4 = 0;
      m_valid = 0; m_stale = 0; m_q.delete();
    end else if (m_stale) begin
      if (kil) m_kill();
      if (imem.ready) m_stale = 0;
    end else if (m_q.size() > 0) begin
      if (kil) begin
        m_q.delete();
        m_kill();
      end else if (!stl) begin
        m_instr = m_q.pop_front();
        m_pc4 = m_pc + 4;
        m_valid = 1;
        m_pc = m_pc + 4;
      end
    end else if (kil) begin
      if (!imem.ready) begin
        m_stale = 1;
        m_old = m_pc;
      end
      m_kill();
    end else if (imem.ready) begin
      if (stl) m_q.push_back(imem.rdata);
      else begin
        m_instr = imem.rdata;
        m_pc4 = m_pc + 4;
        m_valid = 1;
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic step(input bit rs, input bit fl,
                      input bit wn, input bit dl,
                      input bit rd,
                      input logic [31:0] rp,
                      input bit re);
    reset = rs; flush = fl; pc_wen = wn;
    delay = dl; redirect = rd; redirect_pc = rp;
    imem.ready = re && m_req();
    imem.rdata = m_addr() ^ KEY;
    @(posedge clk);
    m_update();
    #1;
    chk("req", {31'b0, imem.req}, {31'b0, m_req()});
    chk("addr", imem.addr, m_addr());
    chk("instr", ifid_instr, m_instr);
    chk("pc4", ifid_pc4, m_pc4);
    chk("valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("pc", pc_out, m_pc);
  endtask

  task automatic run(input bit re);
    step(0, 0, 1, 0, 0, 32'h0, re);
  endtask

  task automatic do_reset();
    step(1, 0, 1, 0, 0, 32'h0, 0);
    step(1, 0, 1, 0, 0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] p;
    reset = 1; flush = 0; pc_wen = 1; delay = 0;
    redirect = 0; redirect_pc = 0;
    imem.ready = 0; imem.rdata = 0;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_old = 0;
    m_valid = 0; m_stale = 0;

    // reset state
    do_reset();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'b0, imem.req}, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, NOP);

    // zero-wait memory
    for (int i = 1; i <= 4; i++) begin
      run(1);
      chk("zw_pc4", ifid_pc4, 32'(4 * i));
      chk("zw_valid", {31'b0, ifid_valid}, 32'h1);
      chk("zw_instr", ifid_instr, 32'(4 * (i - 1)) ^ KEY);
    end
    chk("zw_pc", pc_out, 32'd16);

    // stall two cycles at pc=8
    do_reset();
    run(1); run(1);
    step(0, 0, 0, 1, 0, 32'h0, 1);
    chk("st_pc", pc_out, 32'd8);
    chk("st_pc4", ifid_pc4, 32'd8);
    step(0, 0, 0, 1, 0, 32'h0, 1);
    chk("st_pc_b", pc_out, 32'd8);
    chk("st_valid", {31'b0, ifid_valid}, 32'h1);
    run(1);
    chk("st_resume", ifid_pc4, 32'd12);
    chk("st_rinstr", ifid_instr, 32'd8 ^ KEY);

    // late ready meets a stall
    do_reset();
    run(0); run(0); run(0);
    step(0, 0, 1, 1, 0, 32'h0, 1);
    chk("held_req", {31'b0, imem.req}, 32'h0);
    chk("held_pc", pc_out, 32'h0);
    run(0);
    chk("held_pc4", ifid_pc4, 32'd4);
    chk("held_instr", ifid_instr, KEY);
    chk("held_valid", {31'b0, ifid_valid}, 32'h1);

    // redirect during outstanding fetch to 0x10
    do_reset();
    run(1); run(1); run(1); run(1);
    step(0, 0, 1, 0, 1, 32'h40, 0);
    chk("rd_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rd_addr", imem.addr, 32'h10);
    run(0);
    run(1);
    chk("rd_drop", {31'b0, ifid_valid}, 32'h0);
    run(1);
    chk("rd_pc4", ifid_pc4, 32'h44);
    chk("rd_instr", ifid_instr, 32'h40 ^ KEY);

    // flush and delay together
    p = m_pc;
    step(0, 1, 1, 1, 0, 32'h0, 1);
    chk("fd_instr", ifid_instr, NOP);
    chk("fd_valid", {31'b0, ifid_valid}, 32'h0);
    chk("fd_pc", pc_out, p);

    // reset in the middle of DISCARD
    step(0, 0, 1, 0, 1, 32'h80, 0);
    step(1, 0, 1, 0, 0, 32'h0, 0);
    chk("rdis_pc", pc_out, 32'h0);
    chk("rdis_req", {31'b0, imem.req}, 32'h0);
    chk("rdis_valid", {31'b0, ifid_valid}, 32'h0);
    run(0);
    chk("rdis_addr", imem.addr, 32'h0);
    chk("rdis_req2", {31'b0, imem.req}, 32'h1);

    // wrap past the top of the address space
    step(0, 0, 1, 0, 1, 32'hFFFF_FFFF, 1);
    chk("wr_pc", pc_out, 32'hFFFF_FFFC);
    run(1);
    chk("wr_pc4", ifid_pc4, 32'h0);
    chk("wr_pc2", pc_out, 32'h0);

    // randomized hazards and memory latency
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) != 0,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) == 0,
           ($urandom_range(0, 15) == 0)
             ? 32'hFFFF_FFFE : 32'($urandom),
           $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
